// File: rtl/mesh_term_pkg.sv
// Shared field layout, packet type and terminal-legality check for the mesh
// edge-terminal packet source.
package mesh_term_pkg;

  localparam int ID_W     = 8;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 4;
  localparam int MODE_W   = 1;
  localparam int PYLD_W   = 15;

  localparam int ID_LSB   = 24;
  localparam int ROW_LSB  = 20;
  localparam int COL_LSB  = 16;
  localparam int MODE_BIT = 15;
  localparam int PYLD_LSB = 0;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [MODE_W-1:0] mode;
    logic [PYLD_W-1:0] pyld;
  } mesh_pkt_t;

  // Only edge terminals (outer ring minus the corners) and broadcast are reachable.
  function automatic logic is_legal_term(
    input logic [ROW_W-1:0]       row,
    input logic [COL_W-1:0]       col,
    input int                     rows,
    input int                     colums,
    input logic [ROW_W+COL_W-1:0] bdcst
  );
    int   r;
    int   c;
    logic inner_row;
    logic inner_col;
    logic edge_row;
    logic edge_col;
    r         = int'(row);
    c         = int'(col);
    inner_row = (r >= 1) && (r <= rows);
    inner_col = (c >= 1) && (c <= colums);
    edge_row  = (r == 0) || (r == rows + 1);
    edge_col  = (c == 0) || (c == colums + 1);
    return ({row, col} == bdcst) || (inner_row && edge_col) || (inner_col && edge_row);
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on o_data.
// Push while full and pop while empty are ignored.
module mesh_term_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_src.sv
// Edge-terminal packet source: stamps requests with TERM_ID, drops illegal
// targets, buffers legal packets and feeds one mesh input port.
module mesh_term_src
  import mesh_term_pkg::*;
#(
  parameter int          ROWS       = 4,
  parameter int          COLUMS     = 4,
  parameter int          pckg_sz    = 32,
  parameter int          fifo_depth = 4,
  parameter logic [7:0]  bdcst      = {8{1'b1}},
  parameter logic [7:0]  TERM_ID    = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_row,
  input  logic [3:0]            in_col,
  input  logic                  in_mode,
  input  logic [pckg_sz-18:0]   in_pyld,
  output logic                  pndng_i_in,
  output logic [pckg_sz-1:0]    data_out_i_in,
  input  logic                  popin,
  output logic [15:0]           sent_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int CW = $clog2(fifo_depth) + 1;

  logic [pckg_sz-1:0] w_pkt;
  logic               w_legal;
  logic               w_accept;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [15:0]        r_sent_cnt;
  logic [15:0]        r_drop_cnt;

  always_comb begin
    w_pkt                        = '0;
    w_pkt[ID_LSB +: ID_W]        = TERM_ID;
    w_pkt[ROW_LSB +: ROW_W]      = in_row;
    w_pkt[COL_LSB +: COL_W]      = in_col;
    w_pkt[MODE_BIT]              = in_mode;
    w_pkt[PYLD_LSB +: PYLD_W]    = in_pyld;
  end

  assign w_legal    = is_legal_term(in_row, in_col, ROWS, COLUMS, bdcst);

  // Readiness depends on occupancy only, never on popin.
  assign in_ready   = !w_full;
  assign pndng_i_in = (w_count != '0);

  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && w_legal;
  assign w_drop     = w_accept && !w_legal;
  assign w_pop      = popin && !w_empty;

  mesh_term_fifo #(
    .DW    (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_pkt),
    .i_pop   (w_pop),
    .o_data  (data_out_i_in),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop && (r_sent_cnt != 16'hFFFF)) begin
        r_sent_cnt <= r_sent_cnt + 16'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign sent_cnt = r_sent_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_mesh_term_src.sv
// Scoreboard bench for mesh_term_src: stimulus pushes expected packets into a
// queue, a negedge monitor pops and compares whenever the mesh pops the head.
module tb_mesh_term_src;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_row;
  logic [3:0]  in_col;
  logic        in_mode;
  logic [14:0] in_pyld;
  logic        pndng_i_in;
  logic [31:0] data_out_i_in;
  logic        popin;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;

  int          n_checks;
  int          n_fail;
  int          m_occ;
  int          m_sent;
  int          m_drop;
  logic [31:0] sb_q[$];
  logic        acc;

  mesh_term_src dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .in_col        (in_col),
    .in_mode       (in_mode),
    .in_pyld       (in_pyld),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Independent reference for a 4x4 mesh with broadcast 8'hFF.
  function automatic logic ref_legal(input logic [3:0] r, input logic [3:0] c);
    return ({r, c} == 8'hFF) ||
           ((r >= 1) && (r <= 4) && ((c == 0) || (c == 5))) ||
           ((c >= 1) && (c <= 4) && ((r == 0) || (r == 5)));
  endfunction

  always @(negedge clk) begin
    if (reset && popin && pndng_i_in) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_data: got pop of %h required no pending packet", data_out_i_in);
      end else begin
        check("pop_data", data_out_i_in, sb_q.pop_front());
      end
    end
  end

  // One clock of stimulus; flow-control outputs checked against the model.
  task automatic cycle(input logic v, input logic [3:0] r, input logic [3:0] c,
                       input logic m, input logic [14:0] p, input logic pp,
                       output logic accepted);
    logic do_push;
    logic do_pop;
    in_valid = v;
    in_row   = r;
    in_col   = c;
    in_mode  = m;
    in_pyld  = p;
    popin    = pp;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, m_occ < 4});
    check("pndng", {31'd0, pndng_i_in}, {31'd0, m_occ > 0});
    accepted = v && (m_occ < 4);
    do_push  = accepted && ref_legal(r, c);
    do_pop   = pp && (m_occ > 0);
    if (do_push) sb_q.push_back({8'h01, r, c, m, p});
    if (accepted && !ref_legal(r, c) && m_drop < 65535) m_drop++;
    if (do_pop && m_sent < 65535) m_sent++;
    m_occ = m_occ + int'(do_push) - int'(do_pop);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    popin    = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_sent"}, {16'd0, sent_cnt}, m_sent);
    check({tag, "_drop"}, {16'd0, drop_cnt}, m_drop);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    popin    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_occ  = 0;
    m_sent = 0;
    m_drop = 0;
    sb_q.delete();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 1'b0, 15'd0, 1'b1, acc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_occ    = 0;
    m_sent   = 0;
    m_drop   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_row   = 4'd0;
    in_col   = 4'd0;
    in_mode  = 1'b0;
    in_pyld  = 15'd0;
    popin    = 1'b0;
    @(posedge clk);
    do_reset();

    check("rst_pndng", {31'd0, pndng_i_in}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_data", data_out_i_in, 32'd0);
    check("rst_sent", {16'd0, sent_cnt}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);

    // Single request and its exact packet image
    cycle(1'b1, 4'd4, 4'd5, 1'b1, 15'h5555, 1'b0, acc);
    check("single_pndng", {31'd0, pndng_i_in}, 32'd1);
    check("single_data", data_out_i_in, 32'h0145D555);
    drain(1);
    check("single_after_pndng", {31'd0, pndng_i_in}, 32'd0);
    check("single_sent", {16'd0, sent_cnt}, 32'd1);

    // Fill to full; the fifth request is held until space opens
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 15'h0101, 1'b0, acc);
    cycle(1'b1, 4'd2, 4'd5, 1'b1, 15'h0102, 1'b0, acc);
    cycle(1'b1, 4'd0, 4'd3, 1'b0, 15'h0103, 1'b0, acc);
    cycle(1'b1, 4'd5, 4'd4, 1'b1, 15'h0104, 1'b0, acc);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 4'd3, 4'd0, 1'b1, 15'h07AB, 1'b0, acc);
    check("full_hold0", {31'd0, acc}, 32'd0);
    cycle(1'b1, 4'd3, 4'd0, 1'b1, 15'h07AB, 1'b1, acc);
    check("full_hold1", {31'd0, acc}, 32'd0);
    cycle(1'b1, 4'd3, 4'd0, 1'b1, 15'h07AB, 1'b0, acc);
    check("full_accept", {31'd0, acc}, 32'd1);
    drain(4);
    check_cnts("fill");

    // Pointer wrap over repeated fill/drain
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) begin
        cycle(1'b1, 4'(i + 1), 4'd0, k[0], 15'((k << 4) | i), 1'b0, acc);
      end
      drain(4);
    end
    check_cnts("wrap");

    // Illegal targets and broadcast
    cycle(1'b1, 4'd2, 4'd2, 1'b0, 15'h0AAA, 1'b0, acc);
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 15'h0BBB, 1'b0, acc);
    cycle(1'b1, 4'd6, 4'd1, 1'b0, 15'h0CCC, 1'b0, acc);
    check("illegal_pndng", {31'd0, pndng_i_in}, 32'd0);
    check("illegal_drop", {16'd0, drop_cnt}, 32'd3);
    cycle(1'b1, 4'hF, 4'hF, 1'b1, 15'h1234, 1'b0, acc);
    check("bcast_pndng", {31'd0, pndng_i_in}, 32'd1);
    check("bcast_data", data_out_i_in, 32'h01FF9234);
    drain(1);

    // Steady push/pop at occupancy 2
    cycle(1'b1, 4'd1, 4'd5, 1'b0, 15'h2000, 1'b0, acc);
    cycle(1'b1, 4'd2, 4'd0, 1'b1, 15'h2001, 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 4'(i % 4 + 1), 4'd5, i[0], 15'(16'h3000 + i), 1'b1, acc);
    end
    drain(2);
    check_cnts("stream");

    // Push with popin while empty leaves one entry
    cycle(1'b1, 4'd0, 4'd2, 1'b0, 15'h4444, 1'b1, acc);
    check("empty_pushpop", {31'd0, pndng_i_in}, 32'd1);
    drain(1);
    check("empty_drained", {31'd0, pndng_i_in}, 32'd0);

    // Reset discards queued packets
    cycle(1'b1, 4'd1, 4'd0, 1'b0, 15'h0011, 1'b0, acc);
    cycle(1'b1, 4'd2, 4'd0, 1'b0, 15'h0022, 1'b0, acc);
    cycle(1'b1, 4'd3, 4'd0, 1'b0, 15'h0033, 1'b0, acc);
    do_reset();
    check("rst2_pndng", {31'd0, pndng_i_in}, 32'd0);
    check("rst2_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_sent", {16'd0, sent_cnt}, 32'd0);
    check("rst2_drop", {16'd0, drop_cnt}, 32'd0);
    drain(1);
    check("underflow_sent", {16'd0, sent_cnt}, 32'd0);
    check("underflow_pndng", {31'd0, pndng_i_in}, 32'd0);

    // Saturation of sent_cnt
    for (int i = 0; i < 65540; i++) begin
      cycle(1'b1, 4'd4, 4'd0, 1'b0, 15'(i), 1'b1, acc);
    end
    drain(1);
    check("sat_sent", {16'd0, sent_cnt}, 32'h0000FFFF);
    check_cnts("sat");
    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
